// File: rtl/code_lock_tx_pkg.sv
// Shared definitions for the serial code-lock transmitter: FSM encoding,
// the lock's factory code and width helpers used by the interface and RTL.
package code_lock_tx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_SEND      = 3'd1;
    localparam state_t ST_WAIT_RESP = 3'd2;
    localparam state_t ST_GAP       = 3'd3;
    localparam state_t ST_FIN       = 3'd4;

    localparam logic [2:0] DEFAULT_CODE = 3'b010;

    // ATTEMPT must hold 0 (idle) through MAX_RETRY+1 (last attempt).
    function automatic int attempt_width(input int max_retry);
        return $clog2(max_retry + 2);
    endfunction

    function automatic int count_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/code_lock_tx_if.sv
// Signal bundle between the keypad/controller + lock side (master) and the
// transmitter (slave).
interface code_lock_tx_if
    import code_lock_tx_pkg::*;
#(
    parameter int CODE_LEN  = 3,
    parameter int MAX_RETRY = 2,
    parameter int ATT_W     = attempt_width(MAX_RETRY)
);

    logic                START;
    logic [CODE_LEN-1:0] CODE;
    logic                LOCK;
    logic                ALARM;
    logic                OUT;
    logic                OUT_EN;
    logic                BUSY;
    logic                DONE;
    logic                FAIL;
    logic [ATT_W-1:0]    ATTEMPT;

    modport master (
        output START, CODE, LOCK, ALARM,
        input  OUT, OUT_EN, BUSY, DONE, FAIL, ATTEMPT
    );

    modport slave (
        input  START, CODE, LOCK, ALARM,
        output OUT, OUT_EN, BUSY, DONE, FAIL, ATTEMPT
    );

endinterface

// File: rtl/code_lock_shifter.sv
// Parallel-load, MSB-first shifter that counts the bits handed to the line
// and flags when the whole code has been emitted.
module code_lock_shifter #(
    parameter int CODE_LEN = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                shift,
    input  logic [CODE_LEN-1:0] data,
    output logic                next_bit,
    output logic                last
);

    localparam int BW = $clog2(CODE_LEN + 1);

    logic [CODE_LEN-1:0] sreg;
    logic [BW-1:0]       bits;

    // On load the MSB goes straight to the line, so the register keeps the rest.
    assign next_bit = load ? data[CODE_LEN-1] : sreg[CODE_LEN-1];
    assign last     = (bits == BW'(CODE_LEN));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg <= '0;
            bits <= '0;
        end else if (load) begin
            sreg <= data << 1;
            bits <= BW'(1);
        end else if (shift) begin
            sreg <= sreg << 1;
            bits <= bits + BW'(1);
        end
    end

endmodule

// File: rtl/code_lock_tx.sv
// Initiator side of the serial code lock: sends the latched code MSB first,
// waits for Lock/Alarm, retries after an idle gap and reports DONE or FAIL.
module code_lock_tx
    import code_lock_tx_pkg::*;
#(
    parameter int CODE_LEN     = 3,
    parameter int RESP_TIMEOUT = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int MAX_RETRY    = 2
) (
    input  logic           CLK,
    input  logic           R,
    code_lock_tx_if.slave  bus
);

    localparam int AW = attempt_width(MAX_RETRY);
    localparam int CW = count_width(RESP_TIMEOUT, GAP_CYCLES);

    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(RESP_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
    localparam logic [AW-1:0] RETRY_LIMIT  = AW'(MAX_RETRY);
    localparam logic [AW-1:0] ATT_ONE      = AW'(1);

    state_t              state;
    logic [CODE_LEN-1:0] code_q;
    logic [CW-1:0]       cnt;
    logic                out_q;
    logic                out_en_q;
    logic                busy_q;
    logic                done_q;
    logic                fail_q;
    logic [AW-1:0]       attempt_q;

    logic                accept;
    logic                gap_end;
    logic                retry_ok;
    logic                load;
    logic                shift;
    logic [CODE_LEN-1:0] load_data;
    logic                next_bit;
    logic                last;

    assign accept    = (state == ST_IDLE) && bus.START;
    assign gap_end   = (state == ST_GAP) && (cnt == GAP_LAST);
    assign retry_ok  = (attempt_q <= RETRY_LIMIT);
    assign load      = accept || (gap_end && retry_ok);
    assign shift     = (state == ST_SEND) && !bus.ALARM && !last;
    // Retries replay the latched copy, never the live keypad code.
    assign load_data = (state == ST_IDLE) ? bus.CODE : code_q;

    code_lock_shifter #(
        .CODE_LEN (CODE_LEN)
    ) u_shifter (
        .clk      (CLK),
        .rst_n    (R),
        .load     (load),
        .shift    (shift),
        .data     (load_data),
        .next_bit (next_bit),
        .last     (last)
    );

    always_ff @(posedge CLK) begin
        if (!R) begin
            state     <= ST_IDLE;
            code_q    <= '0;
            cnt       <= '0;
            out_q     <= 1'b0;
            out_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            attempt_q <= '0;
        end else begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.START) begin
                        state     <= ST_SEND;
                        code_q    <= bus.CODE;
                        out_q     <= next_bit;
                        out_en_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        attempt_q <= ATT_ONE;
                    end
                end
                ST_SEND: begin
                    if (bus.ALARM) begin
                        state    <= ST_GAP;
                        cnt      <= '0;
                        out_q    <= 1'b0;
                        out_en_q <= 1'b0;
                    end else if (last) begin
                        state    <= ST_WAIT_RESP;
                        cnt      <= '0;
                        out_q    <= 1'b0;
                        out_en_q <= 1'b0;
                    end else begin
                        out_q <= next_bit;
                    end
                end
                ST_WAIT_RESP: begin
                    // Alarm wins over a simultaneous Lock.
                    if (bus.ALARM || (!bus.LOCK && cnt == TIMEOUT_LAST)) begin
                        state <= ST_GAP;
                        cnt   <= '0;
                    end else if (bus.LOCK) begin
                        state  <= ST_FIN;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (retry_ok) begin
                            state     <= ST_SEND;
                            out_q     <= next_bit;
                            out_en_q  <= 1'b1;
                            attempt_q <= attempt_q + ATT_ONE;
                        end else begin
                            state  <= ST_FIN;
                            fail_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_FIN: begin
                    state     <= ST_IDLE;
                    busy_q    <= 1'b0;
                    attempt_q <= '0;
                end
                default: begin
                    state    <= ST_IDLE;
                    out_q    <= 1'b0;
                    out_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.OUT     = out_q;
    assign bus.OUT_EN  = out_en_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.FAIL    = fail_q;
    assign bus.ATTEMPT = attempt_q;

endmodule
